clk_gate_ctrl: RTL and testbench

Parametrised multi-channel clock-gate controller for the gated core clocks of the TMR RISC-V subsystem. Each of `NUM_CH` channels drives one global clock buffer with a synchronous CE (`CE_TYPE="SYNC"`, no inversions). A per-channel state machine sets that CE so the debug/sequencing logic can halt, free-run or single-step any subset of the redundant cores in lockstep. It sits between the debug/command interface and the clock tree, and replaces the fixed single-enable gate.

---
 rtl/clk_gate_ctrl.sv | 80 ++++++++
 tb/tb_clk_gate_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: per-channel HALT/RUN/STEP state machines driving the synchronous CE
// of one gated clock buffer each, so redundant cores can be halted or stepped in lockstep.
module clk_gate_ctrl #(
    parameter int   NUM_CH    = 3,
    parameter int   CNT_W     = 16,
    parameter logic RESET_RUN = 1'b1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [NUM_CH-1:0] cmd_mask,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);
    typedef enum logic [1:0] {HALTED, RUNNING, STEPPING} state_t;
    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    logic ready_q;
    logic cmd_acc;
    always_ff @(posedge clk_in) ready_q <= !reset;
    assign cmd_ready = ready_q;
    assign cmd_acc   = cmd_valid && ready_q;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             ce_q, busy_q, done_q, gate_q, hit;
        assign hit = cmd_acc && cmd_mask[i];
        always_ff @(posedge clk_in) begin
            if (reset) begin
                state_q <= RESET_RUN ? RUNNING : HALTED;
                cnt_q   <= '0;
                ce_q    <= RESET_RUN;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (hit && cmd_op == OP_HALT) begin
                    state_q <= HALTED;
                    cnt_q   <= '0;
                    ce_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end else if (hit && cmd_op == OP_RUN) begin
                    state_q <= RUNNING;
                    cnt_q   <= '0;
                    ce_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end else if (hit && cmd_op == OP_STEP) begin
                    state_q <= (cmd_count == '0) ? HALTED : STEPPING;
                    cnt_q   <= cmd_count;
                    ce_q    <= (cmd_count != '0);
                    busy_q  <= (cmd_count != '0);
                    done_q  <= (cmd_count == '0);
                end else if (state_q == STEPPING) begin
                    // Last enabled cycle: drop CE and report completion together.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= HALTED;
                        cnt_q   <= '0;
                        ce_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
            end
        end
        // Enable is retimed onto the falling edge so the gate only switches while clk_in is low.
        always_ff @(negedge clk_in) gate_q <= ce_q;
        assign clk_out[i] = clk_in & gate_q;
        assign ce_out[i]  = ce_q;
        assign busy[i]    = busy_q;
        assign done[i]    = done_q;
    end
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: cycle-stamped reference model of the channel rules plus directed
// HALT/RUN/STEP/reset scenarios with literal expectations.
module tb_clk_gate_ctrl;
    localparam int N = 3;
    localparam int W = 16;
    localparam logic [1:0] HALT = 2'b00, RUN = 2'b01, STEP = 2'b10, NOP = 2'b11;
    logic         clk_in = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = NOP;
    logic [N-1:0] cmd_mask = '0;
    logic [W-1:0] cmd_count = '0;
    logic         cmd_ready;
    logic [N-1:0] ce_out, clk_out, busy, done;

    clk_gate_ctrl #(.NUM_CH(N), .CNT_W(W), .RESET_RUN(1'b1)) dut (
        .clk_in(clk_in), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_count(cmd_count),
        .ce_out(ce_out), .clk_out(clk_out), .busy(busy), .done(done)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    int e0 = 0, e1 = 0, e2 = 0;
    always @(posedge clk_out[0]) e0++;
    always @(posedge clk_out[1]) e1++;
    always @(posedge clk_out[2]) e2++;

    int n_chk = 0, n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Model: each channel is free-running, or enabled strictly before an absolute end cycle.
    bit           run[N];
    int           step_end[N], done_at[N];
    int           ready_from = 0;
    bit           started = 0;
    logic [N-1:0] ec, eb, ed;
    always @(negedge clk_in) begin
        if (started) begin
            for (int i = 0; i < N; i++) begin
                ec[i] = run[i] || (cyc < step_end[i]);
                eb[i] = cyc < step_end[i];
                ed[i] = cyc == done_at[i];
            end
            check("model_ce", 32'(ce_out), 32'(ec));
            check("model_busy", 32'(busy), 32'(eb));
            check("model_done", 32'(done), 32'(ed));
            check("model_ready", 32'(cmd_ready), 32'(cyc >= ready_from));
        end
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                run[i] = 1'b1;
                step_end[i] = 0;
                done_at[i] = -1;
            end
            ready_from = cyc + 2;
            started = 1'b1;
        end else if (started && cmd_valid && cyc >= ready_from) begin
            for (int i = 0; i < N; i++) begin
                if (cmd_mask[i] && cmd_op != NOP) begin
                    run[i] = (cmd_op == RUN);
                    step_end[i] = (cmd_op == STEP) ? cyc + int'(cmd_count) + 1 : 0;
                    done_at[i] = (cmd_op == STEP) ? cyc + int'(cmd_count) + 1 : -1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
        cmd_valid = 1'b0;
    endtask
    task automatic issue(input logic [1:0] op, input logic [N-1:0] m, input logic [W-1:0] c);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_mask = m;
        cmd_count = c;
    endtask

    int s0, s1, s2, nce, ndn;
    initial begin
        repeat (3) tick();
        reset = 1'b0;
        issue(HALT, 3'b111, 0);
        @(negedge clk_in);
        check("ready_first", 32'(cmd_ready), 0);
        check("reset_ce", 32'(ce_out), 32'h7);
        check("reset_busy_done", 32'({busy, done}), 0);
        tick();
        @(negedge clk_in);
        check("ready_on", 32'(cmd_ready), 1);
        check("early_cmd_ignored", 32'(ce_out), 32'h7);

        tick();
        issue(HALT, 3'b111, 0);
        repeat (3) tick();
        s0 = e0; s1 = e1; s2 = e2;
        issue(STEP, 3'b111, 5);
        tick();
        @(negedge clk_in);
        check("step5_first", 32'({ce_out, busy}), 32'h3f);
        repeat (4) tick();
        @(negedge clk_in);
        check("step5_last", 32'({ce_out, done}), 32'h38);
        tick();
        @(negedge clk_in);
        check("step5_done", 32'({ce_out, busy, done}), 32'h007);
        tick();
        @(negedge clk_in);
        check("step5_done_once", 32'(done), 0);
        repeat (2) tick();
        check("edges_ch0", 32'(e0 - s0), 5);
        check("edges_ch1", 32'(e1 - s1), 5);
        check("edges_ch2", 32'(e2 - s2), 5);

        tick();
        issue(STEP, 3'b001, 10);
        tick();
        @(negedge clk_in);
        check("abort_start", 32'({ce_out, busy}), 32'h09);
        repeat (3) tick();
        issue(HALT, 3'b001, 0);
        @(negedge clk_in);
        check("abort_before", 32'(ce_out), 32'h1);
        tick();
        @(negedge clk_in);
        check("abort_after", 32'({ce_out, busy}), 0);
        repeat (6) tick();
        @(negedge clk_in);
        check("abort_no_done", 32'(done), 0);

        tick();
        issue(RUN, 3'b111, 0);
        tick();
        issue(STEP, 3'b010, 0);
        @(negedge clk_in);
        check("run_all", 32'(ce_out), 32'h7);
        tick();
        @(negedge clk_in);
        check("step0", 32'({ce_out, busy, done}), 32'h142);
        tick();
        @(negedge clk_in);
        check("step0_done_once", 32'({ce_out, done}), 32'h28);

        tick();
        issue(STEP, 3'b100, 3);
        tick();
        @(negedge clk_in);
        check("rst_step_start", 32'({ce_out, busy}), 32'h2c);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk_in);
        check("rst_mid_step", 32'({ce_out, busy, done}), 32'h1c0);
        check("rst_ready_low", 32'(cmd_ready), 0);
        tick();
        @(negedge clk_in);
        check("rst_no_done", 32'({cmd_ready, done}), 32'h8);

        tick();
        issue(NOP, 3'b111, 0);
        tick();
        issue(HALT, 3'b000, 0);
        tick();
        @(negedge clk_in);
        check("nop_zero_mask", 32'(ce_out), 32'h7);

        tick();
        issue(STEP, 3'b001, 16'hFFFF);
        nce = 0;
        ndn = 0;
        for (int i = 0; i < 65537; i++) begin
            tick();
            @(negedge clk_in);
            nce += int'(ce_out[0]);
            ndn += int'(done[0]);
        end
        check("max_step_len", 32'(nce), 65535);
        check("max_step_done", 32'(ndn), 1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
